led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_pkg.sv | 13 +
 rtl/led_timebase.sv | 58 +++++
 rtl/led_ctrl.sv | 99 +++++++++
 tb/tb_led_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// LED controller shared definitions.
// Register map and per-LED mode encodings.
package led_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_DUTY   = 2'd3;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_BLINK  = 1'b1;

endpackage

// File: rtl/led_timebase.sv
// LED timebase: blink prescaler with phase
// and a free-running brightness PWM counter.
module led_timebase #(
  parameter int PRESC_W = 24,
  parameter int PWM_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] period_i,
  input  logic               period_we_i,
  input  logic [PWM_W-1:0]   duty_i,
  output logic               phase_o,
  output logic               pwm_on_o
);

  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
  localparam logic [PWM_W-1:0]   W_ONE = PWM_W'(1);

  logic [PRESC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;

  // Next blink count/phase; a PERIOD write restarts
  // the half-period and beats a coincident wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pwm_cnt_d   = pwm_cnt_q + W_ONE;
    if (period_we_i) begin
      blink_cnt_d = '0;
    end else if (period_i == '0) begin
      blink_cnt_d = '0;
    end else if (blink_cnt_q == period_i - P_ONE) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + P_ONE;
    end
  end

  // Timebase state; reset restarts both counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pwm_cnt_q   <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign phase_o  = phase_q;
  // Full-scale duty is treated as always on.
  assign pwm_on_o = (&duty_i) | (pwm_cnt_q < duty_i);

endmodule

// File: rtl/led_ctrl.sv
// LED controller: register file, read mux
// and registered LED drive.
module led_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LED = 32,
  parameter int PRESC_W = 24,
  parameter int PWM_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        in,
  output logic [31:0]        out,
  output logic [NUM_LED-1:0] led_light
);

  logic [NUM_LED-1:0] data_q, data_d;
  logic [NUM_LED-1:0] mode_q, mode_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               period_we;
  logic               phase;
  logic               pwm_on;

  assign period_we = we && (addr == ADDR_PERIOD);

  // Register writes; bits above each width drop.
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (we) begin
      unique case (addr)
        ADDR_DATA:   data_d   = in[NUM_LED-1:0];
        ADDR_MODE:   mode_d   = in[NUM_LED-1:0];
        ADDR_PERIOD: period_d = in[PRESC_W-1:0];
        ADDR_DUTY:   duty_d   = in[PWM_W-1:0];
        default:     ;
      endcase
    end
  end

  // Next LED drive: static LEDs ignore the phase.
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      led_d[i] = data_q[i] & pwm_on &
        ((mode_q[i] == MODE_BLINK) ? phase : 1'b1);
    end
  end

  // Register state; reset wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      mode_q   <= '0;
      period_q <= '0;
      duty_q   <= '1;
      led_q    <= '0;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      led_q    <= led_d;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    out = '0;
    unique case (addr)
      ADDR_DATA:   out = 32'(data_q);
      ADDR_MODE:   out = 32'(mode_q);
      ADDR_PERIOD: out = 32'(period_q);
      ADDR_DUTY:   out = 32'(duty_q);
      default:     out = '0;
    endcase
  end

  assign led_light = led_q;

  led_timebase #(
    .PRESC_W (PRESC_W),
    .PWM_W   (PWM_W)
  ) u_tb (
    .clk         (clk),
    .reset       (reset),
    .period_i    (period_q),
    .period_we_i (period_we),
    .duty_i      (duty_q),
    .phase_o     (phase),
    .pwm_on_o    (pwm_on)
  );

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: time-based model checked
// every cycle plus directed literal checks.
module tb_led_ctrl;
  import led_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] out32, out8;
  logic [31:0] led32;
  logic [7:0]  led8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .in        (din),
    .out       (out32),
    .led_light (led32)
  );

  led_ctrl #(.NUM_LED(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .in        (din),
    .out       (out8),
    .led_light (led8)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  // Model: phase derived from elapsed edges since
  // the last PERIOD write, PWM from edges since reset.
  logic [31:0] m_data, m_mode, m_led;
  logic [23:0] m_period;
  logic [7:0]  m_duty;
  logic        m_base;
  int          m_anchor, m_rst;
  int          k = 0;
  bit          m_valid = 0;

  function automatic logic phase_at(input int kk);
    if (m_period == 0) return m_base;
    return m_base ^
      ((((kk - m_anchor) / int'(m_period)) % 2) != 0);
  endfunction

  function automatic logic [31:0] m_reg(
      input logic [1:0] a, input logic [31:0] msk);
    case (a)
      2'd0:    return m_data & msk;
      2'd1:    return m_mode & msk;
      2'd2:    return {8'h0, m_period};
      default: return {24'h0, m_duty};
    endcase
  endfunction

  always @(posedge clk) begin : mdl
    logic ph, pon;
    int   pc;
    k++;
    if (reset) begin
      m_data = 0; m_mode = 0; m_period = 0;
      m_duty = 8'hFF; m_led = 0;
      m_base = 0; m_anchor = k; m_rst = k;
      m_valid = 1;
    end else if (m_valid) begin
      ph  = phase_at(k - 1);
      pc  = ((k - 1) - m_rst) % 256;
      pon = (m_duty == 8'hFF) || (pc < int'(m_duty));
      for (int i = 0; i < 32; i++)
        m_led[i] = m_data[i] && pon &&
                   (m_mode[i] ? ph : 1'b1);
      if (we) begin
        case (addr)
          2'd0: m_data = din;
          2'd1: m_mode = din;
          2'd2: begin
            m_base = ph; m_anchor = k;
            m_period = din[23:0];
          end
          default: m_duty = din[7:0];
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      check("led32", led32, m_led);
      check("led8", {24'h0, led8}, m_led & 32'hFF);
      check("out32", out32, m_reg(addr, 32'hFFFF_FFFF));
      check("out8", out8, m_reg(addr, 32'hFF));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic count_on(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (led32[0]) c++;
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [6:0]  pat7;
    int          cnt;
    reset = 1'b1; we = 1'b0; addr = '0; din = '0;
    tick(3);
    reset = 1'b0;
    #1 check("rst_led", led32, 32'h0);
    addr = ADDR_DUTY;
    #1 check("rst_duty", out32, 32'hFF);

    wr(ADDR_DATA, 32'hA5);
    check("a5_lat", led32, 32'h0);
    tick(1);
    check("a5_led", led32, 32'hA5);
    addr = ADDR_DATA;
    #1 check("a5_out", out32, 32'hA5);

    wr(ADDR_MODE, 32'h1);
    wr(ADDR_DATA, 32'h1);
    wr(ADDR_PERIOD, 32'h4);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      pat[i] = led32[0];
    end
    check("blink_pat", {16'h0, pat}, 32'hF0F0);

    wr(ADDR_PERIOD, 32'h3);
    tick(2);
    wr(ADDR_PERIOD, 32'h5);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      pat7[i] = led32[0];
    end
    check("wrap_ovr", {25'h0, pat7 ^ {7{pat7[0]}}},
          32'h60);

    wr(ADDR_MODE, 32'h0);
    wr(ADDR_DUTY, 32'h1234_5640);
    addr = ADDR_DUTY;
    #1 check("duty_rd", out32, 32'h40);
    tick(1);
    count_on(256, cnt);
    check("duty40", cnt, 64);
    wr(ADDR_DUTY, 32'h0);
    tick(1);
    count_on(256, cnt);
    check("duty00", cnt, 0);
    wr(ADDR_DUTY, 32'hFF);
    tick(1);
    count_on(256, cnt);
    check("dutyFF", cnt, 256);

    wr(ADDR_MODE, 32'h1);
    wr(ADDR_PERIOD, 32'h4);
    tick(6);
    reset = 1'b1; we = 1'b1;
    addr = ADDR_DATA; din = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    #1 check("mr_led", led32, 32'h0);
    check("mr_data", out32, 32'h0);
    addr = ADDR_MODE;
    #1 check("mr_mode", out32, 32'h0);
    addr = ADDR_PERIOD;
    #1 check("mr_per", out32, 32'h0);
    addr = ADDR_DUTY;
    #1 check("mr_duty", out32, 32'hFF);

    wr(ADDR_DATA, 32'h1234_5678);
    tick(1);
    check("plain32", led32, 32'h1234_5678);
    check("plain8", {24'h0, led8}, 32'h78);

    wr(ADDR_DATA, 32'hFFFF_FFFF);
    addr = ADDR_DATA;
    #1 check("w8_out", out8, 32'hFF);
    check("w32_out", out32, 32'hFFFF_FFFF);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
